// File: rtl/alu_mc.sv
// alu_mc: registered multi-cycle ALU, single-cycle ADD/SUB/AND/ORR/EOR plus optional shift-add MUL.
// Define ALU_MC_MUL_EN to build the multiplier; without it opcode 101 is treated as reserved.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    input  logic             set_flags,
    output logic [WIDTH-1:0] Result,
    output logic             out_valid,
    output logic             op_err,
    output logic [3:0]       ALUFlags
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;

    // One completing operation: result, raw flags and which flag pairs it may write.
    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             n;
        logic             z;
        logic             c;
        logic             v;
        logic             wr_nz;
        logic             wr_cv;
        logic             err;
    } cmpl_t;

    logic             accept;
    logic             is_mul;
    logic             acc_single;
    logic             mul_fin;
    logic             pub_vld;
    logic             skid_vld;
    logic             skid_ld;
    cmpl_t            sc;
    cmpl_t            mul_c;
    cmpl_t            pub;
    cmpl_t            skid;
    logic [WIDTH-1:0] condinvb;
    logic [WIDTH:0]   sum;

    assign accept     = in_valid && in_ready;
    assign acc_single = accept && !is_mul;

    always_comb begin
        condinvb = (ALUControl == OP_SUB) ? ~b : b;
        sum      = {1'b0, a} + {1'b0, condinvb} + {{WIDTH{1'b0}}, ALUControl == OP_SUB};
        sc       = '0;
        case (ALUControl)
            OP_ADD, OP_SUB: begin
                sc.res   = sum[WIDTH-1:0];
                sc.c     = sum[WIDTH];
                sc.v     = (a[WIDTH-1] == condinvb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
                sc.wr_cv = set_flags;
            end
            OP_AND:  sc.res = a & b;
            OP_ORR:  sc.res = a | b;
            OP_EOR:  sc.res = a ^ b;
            default: sc.err = 1'b1;
        endcase
        sc.n     = sc.res[WIDTH-1];
        sc.z     = (sc.res == '0);
        sc.wr_nz = set_flags && !sc.err;
    end

`ifdef ALU_MC_MUL_EN
    localparam logic [2:0] OP_MUL = 3'b101;
    localparam int         CNT_W  = $clog2(WIDTH) + 1;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_nxt;
    logic             mul_sf;

    assign is_mul  = (ALUControl == OP_MUL);
    assign mul_fin = (state == S_MUL) && (cnt == CNT_W'(1));
    assign acc_nxt = acc + (mplier[0] ? mcand : '0);

    always_comb begin
        mul_c       = '0;
        mul_c.res   = acc_nxt;
        mul_c.n     = acc_nxt[WIDTH-1];
        mul_c.z     = (acc_nxt == '0);
        mul_c.wr_nz = mul_sf;
    end

    // in_ready rises one cycle before the last iteration so a new op can be taken on the completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            mul_sf   <= 1'b0;
            in_ready <= 1'b1;
        end else begin
            case (state)
                S_IDLE: ;
                S_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(2)) in_ready <= 1'b1;
                    if (mul_fin)          state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
            if (accept && is_mul) begin
                state    <= S_MUL;
                cnt      <= CNT_W'(WIDTH);
                acc      <= '0;
                mcand    <= a;
                mplier   <= b;
                mul_sf   <= set_flags;
                in_ready <= 1'b0;
            end
        end
    end
`else
    assign is_mul   = 1'b0;
    assign mul_fin  = 1'b0;
    assign mul_c    = '0;
    assign in_ready = 1'b1;
`endif

    // A single-cycle op accepted on a MUL completion edge (or behind one) waits one cycle in skid.
    always_comb begin
        pub     = sc;
        pub_vld = acc_single;
        skid_ld = 1'b0;
        if (mul_fin) begin
            pub     = mul_c;
            pub_vld = 1'b1;
            skid_ld = acc_single;
        end else if (skid_vld) begin
            pub     = skid;
            pub_vld = 1'b1;
            skid_ld = acc_single;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Result    <= '0;
            ALUFlags  <= 4'b0000;
            out_valid <= 1'b0;
            op_err    <= 1'b0;
            skid_vld  <= 1'b0;
            skid      <= '0;
        end else begin
            out_valid <= pub_vld;
            op_err    <= pub_vld && pub.err;
            skid_vld  <= skid_ld;
            if (skid_ld) skid <= sc;
            if (pub_vld) begin
                Result <= pub.res;
                if (pub.wr_nz) ALUFlags[3:2] <= {pub.n, pub.z};
                if (pub.wr_cv) ALUFlags[1:0] <= {pub.c, pub.v};
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: scoreboard bench for alu_mc; expected result, flags and completion cycle are
// computed from an arithmetic model when each op is accepted.
module tb_alu_mc;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [2:0]   ALUControl = 3'd0;
    logic         set_flags = 1'b0;
    logic [W-1:0] Result;
    logic         out_valid;
    logic         op_err;
    logic [3:0]   ALUFlags;

    alu_mc #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .ALUControl(ALUControl), .set_flags(set_flags),
        .Result(Result), .out_valid(out_valid), .op_err(op_err), .ALUFlags(ALUFlags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   flags;
        logic         err;
        int           pub;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_pass = 0;
    int         cyc = 0;
    int         pulses = 0;
    int         last_pub = -100;
    logic [3:0] mflags = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Model of one accepted op; flags evolve in acceptance order, which is also completion order.
    task automatic expect_op(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic sf, input int acc);
        exp_t        e;
        longint      t;
        logic [63:0] p;
        logic        c, v, err, cv, mul;
        c = 0; v = 0; err = 0; cv = 0; mul = 0; e.res = '0;
        case (op)
            3'd0: begin
                p = 64'(x) + 64'(y); e.res = p[W-1:0]; c = p[W];
                t = longint'($signed(x)) + longint'($signed(y));
                v = (t != longint'($signed(e.res))); cv = 1;
            end
            3'd1: begin
                e.res = x - y; c = (x >= y);
                t = longint'($signed(x)) - longint'($signed(y));
                v = (t != longint'($signed(e.res))); cv = 1;
            end
            3'd2: e.res = x & y;
            3'd3: e.res = x | y;
            3'd4: e.res = x ^ y;
`ifdef ALU_MC_MUL_EN
            3'd5: begin p = 64'(x) * 64'(y); e.res = p[W-1:0]; mul = 1; end
`endif
            default: err = 1;
        endcase
        if (sf && !err) begin
            mflags[3] = e.res[W-1];
            mflags[2] = (e.res == '0);
            if (cv) mflags[1:0] = {c, v};
        end
        e.flags = mflags;
        e.err = err;
        e.pub = mul ? acc + W : ((acc > last_pub) ? acc : last_pub + 1);
        last_pub = e.pub;
        sb.push_back(e);
    endtask

    // Holds the request until the cycle in_ready is seen high before an edge.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sf);
        logic rdy;
        bit   done;
        done = 0;
        in_valid = 1; ALUControl = op; a = x; b = y; set_flags = sf;
        for (int t = 0; t < 100 && !done; t++) begin
            rdy = in_ready;
            @(negedge clk);
            if (rdy) begin
                done = 1;
                expect_op(op, x, y, sf, cyc);
            end
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        #1;
        if (rst_n && op_err && !out_valid) chk("op_err_alone", 1, 0);
        if (rst_n && out_valid) begin
            pulses++;
            if (sb.size() == 0) chk("spurious_out_valid", 1, 0);
            else begin
                e = sb.pop_front();
                chk("result", Result, e.res);
                chk("flags", ALUFlags, e.flags);
                chk("op_err", op_err, e.err);
                chk("completion_cycle", cyc, e.pub);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int           n0;
        int           lowc;
        logic [2:0]   op;
        logic [W-1:0] x, y;
        #1 rst_n = 0;
        #2;
        chk("rst_result", Result, 0);
        chk("rst_flags", ALUFlags, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_op_err", op_err, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk); @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        n0 = pulses;
        issue(3'd1, 5, 5, 1);
        idle(3);
        chk("sub_pulse_count", pulses - n0, 1);
        chk("sub_flags", ALUFlags, 4'b0110);

        issue(3'd0, 32'h7FFF_FFFF, 1, 1);
        issue(3'd2, 0, 0, 1);
        idle(2);
        chk("and_keeps_cv", ALUFlags, 4'b0101);

        issue(3'd1, 32'hFFFF_FFFF, 1, 1);
        issue(3'd6, 32'h1234, 32'h5678, 1);
        issue(3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
`ifndef ALU_MC_MUL_EN
        issue(3'd5, 32'h10, 32'h20, 1);
`endif
        idle(2);
        chk("reserved_flags_held", ALUFlags, 4'b1010);

        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
`ifdef ALU_MC_MUL_EN
            if (op == 3'd5) op = 3'd1;
`endif
            x = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : 32'($urandom());
            y = ($urandom_range(0, 3) == 0) ? x : 32'($urandom());
            issue(op, x, y, 1'($urandom_range(0, 1)));
        end
        idle(3);

`ifdef ALU_MC_MUL_EN
        issue(3'd5, 32'h0001_0000, 32'h0001_0003, 1);
        in_valid = 0;
        lowc = 0;
        while (!in_ready && lowc < 100) begin
            lowc++;
            @(negedge clk);
        end
        chk("mul_ready_low_cycles", lowc, W - 1);
        idle(3);

        n0 = pulses;
        issue(3'd5, 32'($urandom()), 32'($urandom()), 1);
        issue(3'd0, 123, 456, 1);
        idle(4);
        chk("held_add_pulse_count", pulses - n0, 2);

        issue(3'd5, 32'h1234, 32'h5678, 1);
        idle(10);
        n0 = pulses;
        rst_n = 0;
        #1;
        chk("abort_result", Result, 0);
        chk("abort_flags", ALUFlags, 0);
        chk("abort_in_ready", in_ready, 1);
        sb.delete();
        mflags = 4'b0000;
        last_pub = -100;
        @(negedge clk);
        rst_n = 1;
        idle(W + 5);
        chk("abort_no_out_valid", pulses - n0, 0);
`endif

        chk("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the datapath execute stage. It performs ADD/SUB/AND/ORR/EOR in a single cycle and MUL as an iterative shift-add. Inputs use a valid/ready handshake, outputs are registered with a one-cycle done pulse, and NZCV flags are held in an internal register. The block replaces the purely combinational ALU wherever a registered result and a multiply are needed.

## Interface
- WIDTH, 32: operand/result width in bits (≥ 4).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept a request this cycle.
- a, b  in  WIDTH  operands, unsigned/two's-complement.
- ALUControl  in  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110/111 reserved.
- set_flags  in  1  update flag register with this op's flags.
- Result  out  WIDTH  registered result; holds until the next completion.
- out_valid  out  1  one-cycle pulse when Result is new.
- op_err  out  1  pulses with out_valid for a rejected opcode.
- ALUFlags  out  4  registered {N,Z,C,V}.

## Operation
- Accept occurs when in_valid && in_ready at a rising edge. Operands and opcode are captured at that edge. No backpressure on outputs.
- States:
  - IDLE: in_ready=1. A single-cycle op is accepted and completes the same edge. MUL is accepted and the FSM goes to MUL.
  - MUL: in_ready=0. Iterates one multiplier bit per cycle for WIDTH cycles, then returns to IDLE.
- ADD/SUB: condinvb = SUB ? ~b : b. sum[WIDTH:0] = a + condinvb + SUB.
  - C = sum[WIDTH].
  - V = (a[msb]==condinvb[msb]) && (sum[msb]!=a[msb]).
  - So SUB carry means "no borrow".
- AND/ORR/EOR: bitwise. N and Z are updated; C and V are preserved.
- MUL: Result = low WIDTH bits of a*b (unsigned). N and Z are updated; C and V are preserved.
- N = Result[msb]. Z = (Result==0).
- ALUFlags is written at the completion edge only if set_flags was 1 at accept. Otherwise all four bits are held.
- Reserved opcode: completes in one cycle with Result=0, op_err=1, flags unchanged regardless of set_flags.
- in_valid while in_ready=0 is ignored, not queued. The requester must hold or retry.

## Timing
- Reset (asynchronous assert, synchronous-safe release): Result=0, ALUFlags=0000, out_valid=0, op_err=0, in_ready=1, state IDLE, multiply counter and accumulator cleared.
- Single-cycle ops: accept at edge k. Result, flags and out_valid are visible in cycle k+1. Back-to-back accepts give one result per cycle.
- MUL: accept at edge k. in_ready=0 in cycles k+1..k+WIDTH-1. Completion at edge k+WIDTH: out_valid=1 and in_ready=1 in cycle k+WIDTH+1 (latency WIDTH).
- A new request can be accepted in the completion cycle of MUL.
- Multiplier counter is ceil(log2(WIDTH))+1 bits. It counts WIDTH iterations exactly, with no wrap past zero.
- rst_n asserted mid-MUL aborts the operation. No out_valid follows, and flags and Result return to their reset values.
- out_valid and op_err are never high for more than one consecutive cycle per accepted op.

## Configuration
- ALU_MC_MUL_EN defined: MUL state, counter and accumulator are present, and opcode 101 behaves as above.
- ALU_MC_MUL_EN undefined: no multiplier logic. Opcode 101 is treated as reserved (1-cycle, Result=0, op_err=1, flags held), and the FSM never leaves IDLE (in_ready is constant 1 after reset).

## Test plan
- SUB a=5, b=5, set_flags=1 -> next cycle Result=0, ALUFlags=0110, out_valid one-cycle pulse.
- ADD a=0x7FFFFFFF, b=1, set_flags=1, then AND a=0, b=0, set_flags=1:
  - ADD -> Result=0x80000000, ALUFlags=1001.
  - AND -> Result=0, ALUFlags=0101 (C,V preserved).
- MUL a=0x00010000, b=0x00010003, set_flags=1 (macro on) -> in_ready low 31 cycles, Result=0x00030000 exactly 32 cycles after accept, ALUFlags N=0, Z=0, C/V unchanged.
- in_valid held with ADD during an active MUL -> ignored until in_ready=1, then accepted and completes one cycle later. Exactly two out_valid pulses in total.
- rst_n low 10 cycles into a MUL -> Result=0, ALUFlags=0000, in_ready=1, no out_valid ever asserted for that MUL.
- ALUControl=110, and (macro off) 101, with set_flags=1 and prior flags 1010 -> Result=0, op_err=out_valid=1 for one cycle, ALUFlags stays 1010.
